alu_operand_loader: RTL and testbench

Operand-entry front end for the 3-bit ALU. It turns a single 3-bit switch bank plus one enter button into a sequenced load of A, B and the operation select S. It drives those registered values into the combinational ALU and latches the ALU's 5-bit `ans` one cycle later as a stable, flagged result for display. It sits between board I/O (switches/button) and the ALU, feeding the ALU and consuming its output.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/btn_edge_sync.sv | 46 ++++
 rtl/alu_operand_loader.sv | 129 ++++++++++++
 tb/tb_alu_operand_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the 3-bit ALU slice: default datapath widths and
//   the operand-loader state encoding (also decoded by the display logic).
package alu_pkg;

    localparam int ALU_DATA_W = 3;   // operand width (A, B, switch bank)
    localparam int ALU_SEL_W  = 2;   // ALU op-select width
    localparam int ALU_ANS_W  = 5;   // ALU result width
    localparam int STATE_W    = 3;   // width of the exported state code

    // Codes 5..7 are unused and treated as illegal by the loader.
    typedef enum logic [STATE_W-1:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_S = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync
//   Two-flop synchroniser followed by a rising-edge detector. Produces a
//   single-cycle pulse per press of an asynchronous, debounced button.
//
// Ports:
//   clk   in   system clock (rising edge)
//   rst   in   synchronous, active-high reset
//   btn   in   raw button level, asynchronous to clk
//   pulse out  one-cycle pulse, high in the cycle after the synchronised
//              level first rises
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;
    // Each valid bit marks that the matching sync flop holds a real sample
    // of btn rather than the zero forced by reset.
    logic vld1;
    logic vld2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            vld1  <= 1'b0;
            vld2  <= 1'b0;
            prev  <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            vld1  <= 1'b1;
            vld2  <= vld1;
            // Hold prev high until sync2 carries a real sample, so a button
            // held through reset is never mistaken for a fresh press.
            prev  <= vld2 ? sync2 : 1'b1;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader
//   Sequences A, B and S from one switch bank and an enter button, feeds
//   them to the external combinational ALU and captures its answer one
//   cycle after S is loaded.
//
// Ports:
//   clk          in   system clock (rising edge)
//   rst          in   synchronous, active-high reset (highest priority)
//   din          in   switch value, sampled on a load
//   enter        in   enter button level, asynchronous, debounced
//   abort        in   synchronous abort; clears operands, keeps result
//   A, B, S      out  registered operands / op select to the ALU
//   alu_ans      in   ALU result, combinational from A/B/S
//   result       out  captured alu_ans
//   result_valid out  high while result holds the current operation's
//                     answer: rises at the EXEC->DONE edge, falls on the
//                     edge leaving DONE (or on abort/reset)
//   state        out  current FSM state code for LEDs
module alu_operand_loader #(
    parameter int DATA_W = alu_pkg::ALU_DATA_W,
    parameter int SEL_W  = alu_pkg::ALU_SEL_W,
    parameter int ANS_W  = alu_pkg::ALU_ANS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              enter,
    input  logic              abort,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [SEL_W-1:0]  S,
    input  logic [ANS_W-1:0]  alu_ans,
    output logic [ANS_W-1:0]  result,
    output logic              result_valid,
    output logic [2:0]        state
);

    import alu_pkg::*;

    state_t state_r;
    state_t state_nxt;
    logic   enter_pulse;
    logic   ld_a;
    logic   ld_b;
    logic   ld_s;
    logic   capture;
    logic   clr_valid;
    logic   clr_ops;

    btn_edge_sync u_enter_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   (enter),
        .pulse (enter_pulse)
    );

    // Next-state and register-enable decode.
    always_comb begin
        state_nxt = state_r;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_s      = 1'b0;
        capture   = 1'b0;
        clr_valid = 1'b0;
        clr_ops   = 1'b0;
        if (abort) begin
            state_nxt = LOAD_A;
            clr_ops   = 1'b1;
            clr_valid = 1'b1;
        end else begin
            case (state_r)
                LOAD_A: if (enter_pulse) begin
                    ld_a      = 1'b1;
                    state_nxt = LOAD_B;
                end
                LOAD_B: if (enter_pulse) begin
                    ld_b      = 1'b1;
                    state_nxt = LOAD_S;
                end
                LOAD_S: if (enter_pulse) begin
                    ld_s      = 1'b1;
                    state_nxt = EXEC;
                end
                // alu_ans has settled from A/B/S by the end of this cycle.
                EXEC: begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
                DONE: if (enter_pulse) begin
                    clr_valid = 1'b1;
                    state_nxt = LOAD_A;
                end
                // Illegal codes recover to LOAD_A without touching data.
                default: state_nxt = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= LOAD_A;
            A            <= '0;
            B            <= '0;
            S            <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state_r <= state_nxt;
            if (clr_ops) begin
                A <= '0;
                B <= '0;
                S <= '0;
            end else begin
                if (ld_a) A <= din;
                if (ld_b) B <= din;
                if (ld_s) S <= din[SEL_W-1:0];
            end
            if (capture) begin
                result       <= alu_ans;
                result_valid <= 1'b1;
            end else if (clr_valid) begin
                result_valid <= 1'b0;
            end
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a small ALU model on alu_ans.
module tb_alu_operand_loader;

    logic       clk;
    logic       rst;
    logic [2:0] din;
    logic       enter;
    logic       abort;
    logic [2:0] A;
    logic [2:0] B;
    logic [1:0] S;
    logic [4:0] alu_ans;
    logic [4:0] result;
    logic       result_valid;
    logic [2:0] state;

    int vectors;
    int miscompares;

    alu_operand_loader dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .enter        (enter),
        .abort        (abort),
        .A            (A),
        .B            (B),
        .S            (S),
        .alu_ans      (alu_ans),
        .result       (result),
        .result_valid (result_valid),
        .state        (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU model ----------------
    always_comb begin
        case (S)
            2'd0:    alu_ans = {2'b00, A} + {2'b00, B};
            2'd1:    alu_ans = {2'b00, A} - {2'b00, B};
            2'd2:    alu_ans = {2'b00, A & B};
            default: alu_ans = {2'b00, A | B};
        endcase
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Press: enter rises, FSM acts on the third edge after that.
    task automatic press(input logic [2:0] v);
        din   = v;
        enter = 1'b1;
        step(3);
    endtask

    task automatic release_btn();
        enter = 1'b0;
        step(3);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        din   = 3'd0;
        enter = 1'b0;
        abort = 1'b0;

        // Reset
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_A", 8'(A), 8'd0);
        check("rst_B", 8'(B), 8'd0);
        check("rst_S", 8'(S), 8'd0);
        check("rst_result", 8'(result), 8'd0);
        check("rst_valid", 8'(result_valid), 8'd0);
        check("rst_state", 8'(state), 8'd0);

        // Full load 5 + 3, S=0; also checks the 2-cycle input latency
        din   = 3'd5;
        enter = 1'b1;
        step(2);
        check("lat_state_before", 8'(state), 8'd0);
        step(1);
        check("loadA_state", 8'(state), 8'd1);
        check("loadA_A", 8'(A), 8'd5);
        release_btn();
        press(3'd3);
        check("loadB_state", 8'(state), 8'd2);
        check("loadB_B", 8'(B), 8'd3);
        release_btn();
        press(3'd4);                      // din[2] must be ignored: S=0
        check("loadS_state_exec", 8'(state), 8'd3);
        check("loadS_S", 8'(S), 8'd0);
        check("exec_valid_low", 8'(result_valid), 8'd0);
        step(1);
        check("done_state", 8'(state), 8'd4);
        check("done_result", 8'(result), 8'd8);
        check("done_valid", 8'(result_valid), 8'd1);
        release_btn();
        step(2);
        check("done_hold_state", 8'(state), 8'd4);
        check("done_hold_valid", 8'(result_valid), 8'd1);

        // DONE exit keeps A/B/result
        press(3'd7);
        check("exit_state", 8'(state), 8'd0);
        check("exit_valid", 8'(result_valid), 8'd0);
        check("exit_A", 8'(A), 8'd5);
        check("exit_B", 8'(B), 8'd3);
        check("exit_result", 8'(result), 8'd8);

        // Held button: exactly one advance
        release_btn();
        press(3'd6);
        check("held_state", 8'(state), 8'd1);
        check("held_A", 8'(A), 8'd6);
        step(17);
        check("held_state_20", 8'(state), 8'd1);
        check("held_B_kept", 8'(B), 8'd3);
        release_btn();
        check("held_release_state", 8'(state), 8'd1);
        press(3'd2);
        check("repress_state", 8'(state), 8'd2);
        check("repress_B", 8'(B), 8'd2);
        release_btn();

        // Abort on the same cycle as the enter pulse, in LOAD_S
        din   = 3'd1;
        enter = 1'b1;
        step(2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_state", 8'(state), 8'd0);
        check("abort_A", 8'(A), 8'd0);
        check("abort_B", 8'(B), 8'd0);
        check("abort_S", 8'(S), 8'd0);
        check("abort_valid", 8'(result_valid), 8'd0);
        check("abort_result", 8'(result), 8'd8);
        release_btn();
        check("abort_no_advance", 8'(state), 8'd0);

        // Second operation: 6 - 3 with S=1
        press(3'd6);
        release_btn();
        press(3'd3);
        release_btn();
        press(3'd1);
        check("op2_S", 8'(S), 8'd1);
        step(1);
        check("op2_result", 8'(result), 8'd3);
        check("op2_valid", 8'(result_valid), 8'd1);
        release_btn();

        // Abort in DONE: operands clear, result kept
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_done_state", 8'(state), 8'd0);
        check("abort_done_S", 8'(S), 8'd0);
        check("abort_done_valid", 8'(result_valid), 8'd0);
        check("abort_done_result", 8'(result), 8'd3);

        // Reset in EXEC with enter still held
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        press(3'd2);
        release_btn();
        press(3'd1);
        release_btn();
        press(3'd0);
        check("pre_rst_exec_state", 8'(state), 8'd3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_exec_state", 8'(state), 8'd0);
        check("rst_exec_result", 8'(result), 8'd0);
        check("rst_exec_valid", 8'(result_valid), 8'd0);
        check("rst_exec_A", 8'(A), 8'd0);
        step(6);
        check("held_thru_rst_state", 8'(state), 8'd0);
        release_btn();
        press(3'd4);
        check("post_rst_state", 8'(state), 8'd1);
        check("post_rst_A", 8'(A), 8'd4);
        release_btn();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
